player_hand_bank: RTL and testbench

//  Holds the hand-head addresses (linked-list head pointers into card memory) for
//  NUM_PLAYERS players and runs turn rotation. Each slot replaces the single-player

---
 rtl/player_hand_bank.sv | 128 ++++++++++++
 tb/tb_player_hand_bank.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/player_hand_bank.sv
// Bank of per-player hand-head pointers with turn rotation that skips empty hands.
// The turn pointer only ever visits ids 0..NUM_PLAYERS-1; a full empty lap sets all_empty.
module player_hand_bank #(
   parameter int                NUM_PLAYERS = 4,
   parameter int                PID_W       = 2,
   parameter int                ADDR_W      = 10,
   parameter logic [ADDR_W-1:0] NULL_ADDR   = 10'h3FF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              load,
   input  logic [PID_W-1:0]  load_id,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              start,
   input  logic              advance,
   input  logic [PID_W-1:0]  rd_id,
   output logic [ADDR_W-1:0] rd_hand,
   output logic [PID_W-1:0]  current_id,
   output logic [ADDR_W-1:0] current_hand,
   output logic              current_valid,
   output logic              busy,
   output logic              all_empty
);

   localparam int               SLOTS   = 2**PID_W;
   localparam logic [PID_W-1:0] LAST_ID = PID_W'(NUM_PLAYERS - 1);

   typedef enum logic [1:0] {IDLE, SEEK, ACTIVE} state_t;

   state_t            state_reg, state_next;
   logic [PID_W-1:0]  ptr_reg, ptr_next;
   logic [PID_W-1:0]  lap_reg, lap_next;
   logic [PID_W-1:0]  ptr_inc;
   logic              all_empty_reg, all_empty_next;
   logic              cur_null;

   logic [ADDR_W-1:0] slot_reg  [NUM_PLAYERS];
   logic [ADDR_W-1:0] slot_view [SLOTS];

   // Slot storage; out-of-range load ids match no slot and are dropped.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            slot_reg[i] <= NULL_ADDR;
         end
      end else if (load) begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (load_id == PID_W'(i)) begin
               slot_reg[i] <= load_addr;
            end
         end
      end
   end

   // Pad the id space to a power of two so any id reads back as an empty hand.
   genvar gi;
   generate
      for (gi = 0; gi < SLOTS; gi++) begin : g_view
         if (gi < NUM_PLAYERS) begin : g_live
            assign slot_view[gi] = slot_reg[gi];
         end else begin : g_pad
            assign slot_view[gi] = NULL_ADDR;
         end
      end
   endgenerate

   assign rd_hand       = slot_view[rd_id];
   assign current_hand  = slot_view[ptr_reg];
   assign current_id    = ptr_reg;
   assign current_valid = (state_reg == ACTIVE);
   assign busy          = (state_reg == SEEK);
   assign all_empty     = all_empty_reg;

   assign cur_null = (current_hand == NULL_ADDR);
   assign ptr_inc  = (ptr_reg == LAST_ID) ? '0 : ptr_reg + PID_W'(1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= IDLE;
         ptr_reg       <= '0;
         lap_reg       <= '0;
         all_empty_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         ptr_reg       <= ptr_next;
         lap_reg       <= lap_next;
         all_empty_reg <= all_empty_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      ptr_next       = ptr_reg;
      lap_next       = lap_reg;
      all_empty_next = all_empty_reg;
      if (start) begin
         state_next     = SEEK;
         ptr_next       = '0;
         lap_next       = '0;
         all_empty_next = 1'b0;
      end else begin
         case (state_reg)
            SEEK: begin
               if (!cur_null) begin
                  state_next = ACTIVE;
                  lap_next   = '0;
               end else if (lap_reg == LAST_ID) begin
                  state_next     = IDLE;
                  all_empty_next = 1'b1;
               end else begin
                  ptr_next = ptr_inc;
                  lap_next = lap_reg + PID_W'(1);
               end
            end
            ACTIVE: begin
               // A hand cleared under the current player ends the turn on its own.
               if (advance || cur_null) begin
                  state_next = SEEK;
                  ptr_next   = ptr_inc;
                  lap_next   = '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_player_hand_bank.sv
// Scoreboard bench for player_hand_bank: expected turn/empty events are queued by the
// stimulus and popped by a monitor whenever the bank enters ACTIVE or raises all_empty.
module tb_player_hand_bank;

   localparam int               NP  = 4;
   localparam int               PW  = 3;
   localparam int               AW  = 10;
   localparam logic [AW-1:0]    NUL = 10'h3FF;

   typedef struct packed {
      logic          is_empty;
      logic [PW-1:0] id;
      logic [AW-1:0] hand;
      logic [7:0]    seeks;
   } ev_t;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          load = 1'b0;
   logic [PW-1:0] load_id = '0;
   logic [AW-1:0] load_addr = '0;
   logic          start = 1'b0;
   logic          advance = 1'b0;
   logic [PW-1:0] rd_id = '0;
   logic [AW-1:0] rd_hand;
   logic [PW-1:0] current_id;
   logic [AW-1:0] current_hand;
   logic          current_valid;
   logic          busy;
   logic          all_empty;

   int  vectors = 0;
   int  miscompares = 0;
   ev_t exp_q[$];

   player_hand_bank #(
      .NUM_PLAYERS(NP), .PID_W(PW), .ADDR_W(AW), .NULL_ADDR(NUL)
   ) dut (
      .clk(clk), .resetn(resetn), .load(load), .load_id(load_id), .load_addr(load_addr),
      .start(start), .advance(advance), .rd_id(rd_id), .rd_hand(rd_hand),
      .current_id(current_id), .current_hand(current_hand),
      .current_valid(current_valid), .busy(busy), .all_empty(all_empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   // Monitor: one pop per presented event, with the SEEK cycles seen since the last one.
   initial begin
      logic prev_valid;
      logic prev_empty;
      int   busy_cnt;
      ev_t  e;
      prev_valid = 1'b0;
      prev_empty = 1'b0;
      busy_cnt   = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            prev_valid = 1'b0;
            prev_empty = 1'b0;
            busy_cnt   = 0;
         end else begin
            if (busy) busy_cnt++;
            if ((current_valid && !prev_valid) || (all_empty && !prev_empty)) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_event actual id=%0d hand=%0h empty=%0b required=none",
                           current_id, current_hand, all_empty);
               end else begin
                  e = exp_q.pop_front();
                  check("ev_all_empty", 32'(all_empty), 32'(e.is_empty));
                  check("ev_id", 32'(current_id), 32'(e.id));
                  check("ev_hand", 32'(current_hand), 32'(e.hand));
                  check("ev_seek_cycles", 32'(busy_cnt), 32'(e.seeks));
               end
               busy_cnt = 0;
            end
            prev_valid = current_valid;
            prev_empty = all_empty;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_ev(input logic emp, input int id, input logic [AW-1:0] hand, input int seeks);
      ev_t e;
      e.is_empty = emp;
      e.id       = PW'(id);
      e.hand     = hand;
      e.seeks    = 8'(seeks);
      exp_q.push_back(e);
   endtask

   task automatic do_load(input int id, input logic [AW-1:0] addr);
      load      = 1'b1;
      load_id   = PW'(id);
      load_addr = addr;
      tick();
      load = 1'b0;
   endtask

   task automatic pulse(input logic s, input logic a);
      start   = s;
      advance = a;
      tick();
      start   = 1'b0;
      advance = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain_timeout actual pending=%0d required=0", exp_q.size());
         exp_q.delete();
      end
      tick();
   endtask

   task automatic check_slot(input int id, input logic [AW-1:0] req);
      rd_id = PW'(id);
      #1;
      check($sformatf("rd_hand[%0d]", id), 32'(rd_hand), 32'(req));
   endtask

   initial begin
      logic [AW-1:0] init_hands [NP];
      init_hands[0] = 10'h010;
      init_hands[1] = 10'h020;
      init_hands[2] = 10'h030;
      init_hands[3] = 10'h040;

      // Reset state
      repeat (3) tick();
      resetn = 1'b1;
      tick();
      for (int i = 0; i <= NP; i++) check_slot(i, NUL);
      check("reset_current_valid", 32'(current_valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_all_empty", 32'(all_empty), 32'd0);

      // Load four hands, start: one SEEK cycle then player 0
      for (int i = 0; i < NP; i++) do_load(i, init_hands[i]);
      expect_ev(1'b0, 0, 10'h010, 1);
      pulse(1'b1, 1'b0);
      drain();

      // Four advances wrap 1,2,3,0
      for (int i = 1; i <= NP; i++) begin
         expect_ev(1'b0, i % NP, init_hands[i % NP], 1);
         pulse(1'b0, 1'b1);
         drain();
      end

      // Skip two empty hands: 3 SEEK cycles to reach player 3
      do_load(1, NUL);
      do_load(2, NUL);
      expect_ev(1'b0, 3, 10'h040, 1 + 2);
      pulse(1'b0, 1'b1);
      drain();

      // Clearing the active hand with everything else empty: full lap then all_empty
      do_load(0, NUL);
      do_load(1, NUL);
      do_load(2, NUL);
      expect_ev(1'b1, 3, NUL, NP);
      do_load(3, NUL);
      drain();
      check("all_empty_after_lap", 32'(all_empty), 32'd1);
      check("idle_valid_after_lap", 32'(current_valid), 32'd0);

      // Start on an all-empty bank: 4 SEEK cycles, then all_empty again
      expect_ev(1'b1, 3, NUL, NP);
      pulse(1'b1, 1'b0);
      drain();

      // Load plus start clears all_empty and finds player 2
      do_load(2, 10'h123);
      expect_ev(1'b0, 2, 10'h123, 3);
      pulse(1'b1, 1'b0);
      drain();
      check("all_empty_cleared", 32'(all_empty), 32'd0);

      // Clearing the active hand auto-advances to player 3
      do_load(3, 10'h077);
      expect_ev(1'b0, 3, 10'h077, 1);
      do_load(2, NUL);
      drain();

      // Out-of-range load id changes nothing
      do_load(4, 10'h055);
      check_slot(0, NUL);
      check_slot(1, NUL);
      check_slot(2, NUL);
      check_slot(3, 10'h077);
      check_slot(4, NUL);
      check("oor_current_id", 32'(current_id), 32'd3);

      // Advance wraps past empty 0 to player 1
      do_load(1, 10'h0AB);
      expect_ev(1'b0, 1, 10'h0AB, 2);
      pulse(1'b0, 1'b1);
      drain();

      // start and advance together: start wins (restart from 0 lands on 1, not 3)
      expect_ev(1'b0, 1, 10'h0AB, 2);
      pulse(1'b1, 1'b1);
      drain();

      // Reset during SEEK clears everything at once
      pulse(1'b0, 1'b1);
      check("busy_before_reset", 32'(busy), 32'd1);
      resetn = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(current_valid), 32'd0);
      check("rst_current_id", 32'(current_id), 32'd0);
      for (int i = 0; i < NP; i++) check_slot(i, NUL);
      tick();
      resetn = 1'b1;
      repeat (3) tick();
      check("post_rst_valid", 32'(current_valid), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("pending_events", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
